branch_predict_ctrl: RTL and testbench
======================================

# branch_predict_ctrl

Parametrised stage-3 branch resolution and prediction unit for the 3-stage RISC-V core. Holds a table of saturating counters indexed by PC, supplies a taken/not-taken prediction to stage 1, and resolves branches in stage 3. On resolution it updates the table and drives `pc_sel`, including recovery from mispredictions. Also keeps branch and misprediction statistics counters for the CSR/MMIO path.

## Interface
- `ENTRIES`, 32: counter-table depth; power of 2, ≥ 2.
- `CNT_BITS`, 2: width of each saturating counter; ≥ 1.
- `PC_WIDTH`, 32: PC width.
- `STAT_WIDTH`, 32: width of the statistics counters.

- `clk` in 1: the only clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pred_pc` in PC_WIDTH: stage-1 PC.
- `pred_instr` in 32: stage-1 instruction.
- `pred_taken` out 1: combinational prediction for `pred_instr`.
- `upd_valid` in 1: stage-3 instruction is valid (not a bubble).
- `upd_pc` in PC_WIDTH: stage-3 PC.
- `upd_instr` in 32: stage-3 instruction.
- `upd_pred_taken` in 1: prediction carried down the pipe with this instruction.
- `breq`, `brlt` in 1 each: comparator results. Signed/unsigned selection is already applied upstream.
- `pc_sel` out 2: 0 = sequential, 1 = ALU target, 2 = `upd_pc`+4 recovery, 3 = reset vector.
- `flush` out 1: kill the younger stage-1/2 instructions.
- `stat_clear` in 1: zero both statistics counters.
- `branch_cnt`, `mispred_cnt` out STAT_WIDTH: resolved branches and mispredictions.

## Operation
- Table index = `pc[IDX+1:2]`, where IDX = log2(ENTRIES). Taken is predicted when the counter MSB is 1.
- `pred_taken` is 1 only when `pred_instr[6:2]` is the BRANCH opcode and the indexed MSB is 1. It is 0 for every other opcode.
- Stage-3 actual outcome by func3:
  - BEQ: `breq`.
  - BNE: `!breq`.
  - BLT, BLTU: `brlt`.
  - BGE, BGEU: `!brlt`.
  - func3 010/011: not taken; no table update; not counted.
- Table update applies only to a valid branch with a legal func3:
  - Taken: counter +1, saturating at 2^CNT_BITS−1.
  - Not taken: counter −1, saturating at 0.
- `pc_sel` priority:
  1. `rst` → 3.
  2. Valid JAL/JALR → 1, with `flush`=1. Jumps are never predicted.
  3. Valid branch where actual taken and predicted not → 1, with `flush`=1.
  4. Valid branch where actual not taken and predicted taken → 2, with `flush`=1.
  5. Everything else → 0, with `flush`=0. This includes correct predictions, bubbles and non-control opcodes.
- `mispredict` = cases 3 and 4. Every valid legal branch increments `branch_cnt`; a mispredict also increments `mispred_cnt`. Both wrap modulo 2^STAT_WIDTH.
- `stat_clear` takes priority over a same-cycle increment: the counters read 0 next cycle.
- Reset:
  - All table entries go to weakly-not-taken, i.e. 2^(CNT_BITS−1)−1 (01 for 2-bit). For CNT_BITS=1 this is 0.
  - `branch_cnt`=`mispred_cnt`=0.
  - `pc_sel`=3, `flush`=0.
  - `pred_taken`=0 while `rst` is high.
- Reset asserted mid-operation discards the update in flight. No table or statistics write occurs in a reset cycle.

## Timing
- `pred_taken`, `pc_sel`, `flush`: combinational, same cycle as their inputs.
- Table and statistics writes take effect at the next rising edge. Outputs reflect them one cycle after resolution.
- A same-cycle predict and update to the same index: `pred_taken` uses the pre-update value. There is no bypass.
- A stalled stage 3 is presented by the pipeline as `upd_valid`=0. The block has no stall input.

## Structure
- Opcode (`OPC_*_5`), func3 (`FNC_*`) and `pc_sel` encodings come from the shared opcode/control header. The `pc_sel` encodings are added there as named constants so stage 1 decodes them identically.
- One sub-module: `sat_counter_table`, parametrised by ENTRIES and CNT_BITS.
  - One combinational read port.
  - One write port with inc/dec and saturation.
  - Synchronous reset to the weak-not-taken value.

## Test plan
- Reset: hold `rst` 2 cycles → `pc_sel`=3, `flush`=0, stats 0. After release, a BEQ at 0x100 predicts 0 (entry = 01).
- Training: BEQ at 0x100 resolved taken twice (`breq`=1). The first resolution has `upd_pred_taken`=0, giving `pc_sel`=1, `flush`=1 and `mispred_cnt`=1. Afterwards the entry is 11 and `pred_taken`=1. A further taken resolution saturates at 11, with `pc_sel`=0 and `branch_cnt`=3.
- Recovery: BNE with `breq`=1 and `upd_pred_taken`=1 → `pc_sel`=2, `flush`=1; the entry decrements.
- Aliasing and same-cycle collision: with ENTRIES=32, PCs 0x100 and 0x180 share an index. Predict 0x180 while updating 0x100 in the same cycle → the old value is returned; the new value is seen next cycle.
- Non-branch traffic: JALR → `pc_sel`=1, no table or stats change. func3=010 branch → `pc_sel`=0, no change. `upd_valid`=0 with a branch opcode → no change.
- Stats: drive `stat_clear` and a mispredict in the same cycle → both counters read 0. With STAT_WIDTH=4, 16 branches wrap `branch_cnt` to 0.

Source files
------------

// File: rtl/branch_predict_ctrl_pkg.sv
// rtl/branch_predict_ctrl_pkg.sv - shared opcode, func3 and pc_sel encodings for branch handling
package branch_predict_ctrl_pkg;

  // Major opcodes, instr[6:2]
  localparam logic [4:0] OPC_BRANCH_5 = 5'b11000;
  localparam logic [4:0] OPC_JAL_5    = 5'b11011;
  localparam logic [4:0] OPC_JALR_5   = 5'b11001;

  // Branch func3, instr[14:12]
  localparam logic [2:0] FNC_BEQ  = 3'b000;
  localparam logic [2:0] FNC_BNE  = 3'b001;
  localparam logic [2:0] FNC_BLT  = 3'b100;
  localparam logic [2:0] FNC_BGE  = 3'b101;
  localparam logic [2:0] FNC_BLTU = 3'b110;
  localparam logic [2:0] FNC_BGEU = 3'b111;

  // Next-PC select; stage 1 decodes these same names
  typedef enum logic [1:0] {
    PC_SEL_SEQ     = 2'd0,
    PC_SEL_ALU     = 2'd1,
    PC_SEL_RECOVER = 2'd2,
    PC_SEL_RESET   = 2'd3
  } pc_sel_e;

  typedef struct packed {
    logic legal;
    logic taken;
  } br_res_t;

  // Weakly-not-taken counter value: just below the taken threshold
  function automatic int weak_nt_value(input int cnt_bits);
    return (1 << (cnt_bits - 1)) - 1;
  endfunction

  // Actual branch outcome from the comparator flags; 010/011 are not branches
  function automatic br_res_t branch_resolve(input logic [2:0] fnc, input logic breq,
                                             input logic brlt);
    br_res_t r;
    r.legal = 1'b1;
    r.taken = 1'b0;
    case (fnc)
      FNC_BEQ:            r.taken = breq;
      FNC_BNE:            r.taken = !breq;
      FNC_BLT, FNC_BLTU:  r.taken = brlt;
      FNC_BGE, FNC_BGEU:  r.taken = !brlt;
      default:            r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/branch_predict_ctrl_sat_counter_table.sv
// rtl/branch_predict_ctrl_sat_counter_table.sv - table of saturating counters, one read and one inc/dec write port
module sat_counter_table
  import branch_predict_ctrl_pkg::*;
#(
  parameter int ENTRIES  = 32,
  parameter int CNT_BITS = 2,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    rd_idx,
  output logic [CNT_BITS-1:0] rd_cnt,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic                wr_inc
);

  localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;
  localparam logic [CNT_BITS-1:0] CNT_WEAK = CNT_BITS'(weak_nt_value(CNT_BITS));

  logic [CNT_BITS-1:0] cnt_q [ENTRIES];
  logic [CNT_BITS-1:0] cnt_d [ENTRIES];

  // Read is from the registered array, so a same-cycle write is not visible
  assign rd_cnt = cnt_q[rd_idx];

  // Step the addressed counter up or down, holding at either end
  always_comb begin
    cnt_d = cnt_q;
    if (wr_en) begin
      if (wr_inc) begin
        if (cnt_q[wr_idx] != CNT_MAX) cnt_d[wr_idx] = cnt_q[wr_idx] + 1'b1;
      end else begin
        if (cnt_q[wr_idx] != '0) cnt_d[wr_idx] = cnt_q[wr_idx] - 1'b1;
      end
    end
  end

  // Every entry restarts weakly-not-taken
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_WEAK;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/branch_predict_ctrl.sv
// rtl/branch_predict_ctrl.sv - branch prediction, stage-3 resolution, pc_sel/flush and statistics
module branch_predict_ctrl
  import branch_predict_ctrl_pkg::*;
#(
  parameter int ENTRIES    = 32,
  parameter int CNT_BITS   = 2,
  parameter int PC_WIDTH   = 32,
  parameter int STAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   pred_pc,
  input  logic [31:0]           pred_instr,
  output logic                  pred_taken,
  input  logic                  upd_valid,
  input  logic [PC_WIDTH-1:0]   upd_pc,
  input  logic [31:0]           upd_instr,
  input  logic                  upd_pred_taken,
  input  logic                  breq,
  input  logic                  brlt,
  output logic [1:0]            pc_sel,
  output logic                  flush,
  input  logic                  stat_clear,
  output logic [STAT_WIDTH-1:0] branch_cnt,
  output logic [STAT_WIDTH-1:0] mispred_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0]      pred_idx;
  logic [IDX_W-1:0]      upd_idx;
  logic [CNT_BITS-1:0]   pred_cnt;
  logic                  tbl_wr_en;
  logic                  tbl_wr_inc;
  logic                  legal_branch;
  logic                  mispredict;
  br_res_t               res;
  pc_sel_e               pc_sel_d;
  logic                  flush_d;
  logic [STAT_WIDTH-1:0] branch_cnt_q, branch_cnt_d;
  logic [STAT_WIDTH-1:0] mispred_cnt_q, mispred_cnt_d;
  logic                  unused_bits;

  assign pred_idx = pred_pc[IDX_W+1:2];
  assign upd_idx  = upd_pc[IDX_W+1:2];

  sat_counter_table #(
    .ENTRIES  (ENTRIES),
    .CNT_BITS (CNT_BITS)
  ) u_table (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (pred_idx),
    .rd_cnt (pred_cnt),
    .wr_en  (tbl_wr_en),
    .wr_idx (upd_idx),
    .wr_inc (tbl_wr_inc)
  );

  // Only conditional branches are predicted; jumps always resolve in stage 3
  assign pred_taken = !rst && (pred_instr[6:2] == OPC_BRANCH_5) && pred_cnt[CNT_BITS-1];

  // Resolve the stage-3 instruction and pick the next PC source
  always_comb begin
    res          = branch_resolve(upd_instr[14:12], breq, brlt);
    legal_branch = upd_valid && (upd_instr[6:2] == OPC_BRANCH_5) && res.legal;
    mispredict   = legal_branch && (res.taken != upd_pred_taken);
    pc_sel_d     = PC_SEL_SEQ;
    flush_d      = 1'b0;
    if (rst) begin
      pc_sel_d = PC_SEL_RESET;
    end else if (upd_valid && ((upd_instr[6:2] == OPC_JAL_5) || (upd_instr[6:2] == OPC_JALR_5))) begin
      pc_sel_d = PC_SEL_ALU;
      flush_d  = 1'b1;
    end else if (mispredict && res.taken) begin
      pc_sel_d = PC_SEL_ALU;
      flush_d  = 1'b1;
    end else if (mispredict) begin
      pc_sel_d = PC_SEL_RECOVER;
      flush_d  = 1'b1;
    end
    tbl_wr_en  = legal_branch && !rst;
    tbl_wr_inc = res.taken;
  end

  assign pc_sel = pc_sel_d;
  assign flush  = flush_d;

  // Statistics next state; clear wins over a same-cycle increment
  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (stat_clear) begin
      branch_cnt_d  = '0;
      mispred_cnt_d = '0;
    end else begin
      if (legal_branch) branch_cnt_d = branch_cnt_q + 1'b1;
      if (mispredict) mispred_cnt_d = mispred_cnt_q + 1'b1;
    end
  end

  // Statistics registers; a reset cycle never counts
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

  // PC bits outside the index and instruction fields not decoded here
  assign unused_bits = ^{pred_pc[PC_WIDTH-1:IDX_W+2], pred_pc[1:0],
                         upd_pc[PC_WIDTH-1:IDX_W+2], upd_pc[1:0],
                         pred_instr[31:7], pred_instr[1:0],
                         upd_instr[31:15], upd_instr[11:7], upd_instr[1:0]};

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb/tb_branch_predict_ctrl.sv - directed scoreboard bench for branch_predict_ctrl
module tb_branch_predict_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pred_pc;
  logic [31:0] pred_instr;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_instr;
  logic        upd_pred_taken;
  logic        breq;
  logic        brlt;
  logic [1:0]  pc_sel;
  logic        flush;
  logic        stat_clear;
  logic [3:0]  branch_cnt;
  logic [3:0]  mispred_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       pred;
    logic [1:0] sel;
    logic       fl;
    logic [3:0] bcnt;
    logic [3:0] mcnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state (post-edge view)
  logic [1:0] m_tbl [32];
  logic [3:0] m_b;
  logic [3:0] m_m;

  always #5 clk = ~clk;

  branch_predict_ctrl #(
    .ENTRIES    (32),
    .CNT_BITS   (2),
    .PC_WIDTH   (32),
    .STAT_WIDTH (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .pred_pc        (pred_pc),
    .pred_instr     (pred_instr),
    .pred_taken     (pred_taken),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_instr      (upd_instr),
    .upd_pred_taken (upd_pred_taken),
    .breq           (breq),
    .brlt           (brlt),
    .pc_sel         (pc_sel),
    .flush          (flush),
    .stat_clear     (stat_clear),
    .branch_cnt     (branch_cnt),
    .mispred_cnt    (mispred_cnt)
  );

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
    return {17'd0, f3, 5'd0, op};
  endfunction

  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One directed step: drive, predict from the model, compare comb outputs, then stats after the edge
  task automatic cycle(input string tag, input logic r, input logic [31:0] ppc,
                       input logic [31:0] pins, input logic v, input logic [31:0] upc,
                       input logic [31:0] uins, input logic upt, input logic beq,
                       input logic blt, input logic clr);
    exp_t e;
    logic legal, taken, isbr, jmp, mis;
    logic [4:0] opc;
    logic [4:0] ui;
    @(negedge clk);
    rst = r; pred_pc = ppc; pred_instr = pins; upd_valid = v; upd_pc = upc;
    upd_instr = uins; upd_pred_taken = upt; breq = beq; brlt = blt; stat_clear = clr;
    e.pred = !r && (pins[6:2] == 5'b11000) && m_tbl[ppc[6:2]][1];
    opc = uins[6:2];
    legal = 1'b1;
    case (uins[14:12])
      3'd0: taken = beq;
      3'd1: taken = !beq;
      3'd4, 3'd6: taken = blt;
      3'd5, 3'd7: taken = !blt;
      default: begin taken = 1'b0; legal = 1'b0; end
    endcase
    isbr = v && (opc == 5'b11000) && legal;
    jmp  = v && ((opc == 5'b11011) || (opc == 5'b11001));
    mis  = isbr && (taken != upt);
    if (r) begin e.sel = 2'd3; e.fl = 1'b0; end
    else if (jmp) begin e.sel = 2'd1; e.fl = 1'b1; end
    else if (mis && taken) begin e.sel = 2'd1; e.fl = 1'b1; end
    else if (mis) begin e.sel = 2'd2; e.fl = 1'b1; end
    else begin e.sel = 2'd0; e.fl = 1'b0; end
    ui = upc[6:2];
    if (r) begin
      for (int i = 0; i < 32; i++) m_tbl[i] = 2'b01;
      m_b = '0; m_m = '0;
    end else begin
      if (isbr) begin
        if (taken && m_tbl[ui] != 2'b11) m_tbl[ui] = m_tbl[ui] + 2'd1;
        if (!taken && m_tbl[ui] != 2'b00) m_tbl[ui] = m_tbl[ui] - 2'd1;
      end
      if (clr) begin m_b = '0; m_m = '0; end
      else begin
        if (isbr) m_b = m_b + 4'd1;
        if (mis) m_m = m_m + 4'd1;
      end
    end
    e.bcnt = m_b; e.mcnt = m_m;
    exp_q.push_back(e);
    #1;
    e = exp_q.pop_front();
    check({tag, ".pred_taken"}, 32'(pred_taken), 32'(e.pred));
    check({tag, ".pc_sel"}, 32'(pc_sel), 32'(e.sel));
    check({tag, ".flush"}, 32'(flush), 32'(e.fl));
    @(posedge clk);
    #1;
    check({tag, ".branch_cnt"}, 32'(branch_cnt), 32'(e.bcnt));
    check({tag, ".mispred_cnt"}, 32'(mispred_cnt), 32'(e.mcnt));
  endtask

  // Bubble cycle that only probes the prediction for a BEQ at ppc
  task automatic peek(input string tag, input logic [31:0] ppc, input logic exp);
    @(negedge clk);
    rst = 1'b0; pred_pc = ppc; pred_instr = mk(3'd0, OP_BR); upd_valid = 1'b0;
    stat_clear = 1'b0;
    #1;
    check(tag, 32'(pred_taken), 32'(exp));
  endtask

  initial begin
    logic [2:0] legal_f3 [6];
    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd4;
    legal_f3[3] = 3'd5; legal_f3[4] = 3'd6; legal_f3[5] = 3'd7;
    for (int i = 0; i < 32; i++) m_tbl[i] = 2'b01;
    m_b = '0; m_m = '0;

    rst = 1'b1; pred_pc = 32'h100; pred_instr = mk(3'd0, OP_BR); upd_valid = 1'b0;
    upd_pc = '0; upd_instr = '0; upd_pred_taken = 1'b0; breq = 1'b0; brlt = 1'b0;
    stat_clear = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("reset.pc_sel", 32'(pc_sel), 32'd3);
    check("reset.flush", 32'(flush), 32'd0);
    check("reset.pred_taken", 32'(pred_taken), 32'd0);
    check("reset.branch_cnt", 32'(branch_cnt), 32'd0);
    check("reset.mispred_cnt", 32'(mispred_cnt), 32'd0);

    peek("post_reset.pred_0x100", 32'h100, 1'b0);

    // Training
    cycle("train1", 0, 32'h100, mk(3'd0, OP_BR), 1, 32'h100, mk(3'd0, OP_BR), 0, 1, 0, 0);
    check("train1.mispred_const", 32'(mispred_cnt), 32'd1);
    cycle("train2", 0, 32'h100, mk(3'd0, OP_BR), 1, 32'h100, mk(3'd0, OP_BR), 1, 1, 0, 0);
    peek("train.pred_after", 32'h100, 1'b1);
    cycle("train3", 0, 32'h100, mk(3'd0, OP_BR), 1, 32'h100, mk(3'd0, OP_BR), 1, 1, 0, 0);
    check("train3.branch_const", 32'(branch_cnt), 32'd3);

    // Recovery: BNE with equal operands, predicted taken
    cycle("recover", 0, 32'h104, mk(3'd0, OP_ADDI), 1, 32'h100, mk(3'd1, OP_BR), 1, 1, 0, 0);

    // Aliasing collision: predict 0x180 while 0x100 decrements 10 -> 01
    cycle("collide", 0, 32'h180, mk(3'd0, OP_BR), 1, 32'h100, mk(3'd0, OP_BR), 1, 0, 0, 0);
    peek("collide.next", 32'h180, 1'b0);

    // Non-branch traffic
    cycle("jalr", 0, 32'h200, mk(3'd0, OP_BR), 1, 32'h100, mk(3'd0, OP_JALR), 0, 1, 1, 0);
    cycle("jal", 0, 32'h200, mk(3'd0, OP_ADDI), 1, 32'h100, mk(3'd0, OP_JAL), 1, 0, 0, 0);
    cycle("f3_010", 0, 32'h100, mk(3'd0, OP_BR), 1, 32'h100, mk(3'd2, OP_BR), 0, 1, 1, 0);
    cycle("bubble", 0, 32'h100, mk(3'd0, OP_BR), 0, 32'h100, mk(3'd0, OP_BR), 0, 1, 1, 0);
    cycle("addi", 0, 32'h100, mk(3'd0, OP_BR), 1, 32'h100, mk(3'd0, OP_ADDI), 1, 0, 0, 0);
    peek("nonbranch.pred_0x100", 32'h100, 1'b0);

    // Clear beats a same-cycle mispredict
    cycle("clear", 0, 32'h100, mk(3'd0, OP_BR), 1, 32'h140, mk(3'd4, OP_BR), 0, 0, 1, 1);
    check("clear.branch_const", 32'(branch_cnt), 32'd0);
    check("clear.mispred_const", 32'(mispred_cnt), 32'd0);

    // Sixteen legal branches of mixed kinds wrap the 4-bit branch counter
    for (int k = 0; k < 16; k++) begin
      logic [31:0] pc;
      pc = 32'h1000 + 32'($urandom_range(0, 7) * 4);
      cycle($sformatf("wrap%0d", k), 0, pc, mk(3'd0, OP_BR), 1, pc,
            mk(legal_f3[$urandom_range(0, 5)], OP_BR), 1'($urandom), 1'($urandom),
            1'($urandom), 0);
    end
    check("wrap.branch_const", 32'(branch_cnt), 32'd0);

    // Mid-operation reset discards a mispredicting branch in flight
    cycle("midrst", 1, 32'h100, mk(3'd0, OP_BR), 1, 32'h1000, mk(3'd0, OP_BR), 0, 1, 0, 0);
    cycle("after_rst", 0, 32'h1000, mk(3'd0, OP_BR), 0, 32'h0, mk(3'd0, OP_ADDI), 0, 0, 0, 0);
    peek("after_rst.pred_0x1000", 32'h1000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
